// File: rtl/leaf_loopback_probe.sv
// leaf_loopback_probe: BFT-side initiator for a page's leaf interface.
// Sends one packet, strobes resend, waits for the echo, retries on timeout.
module leaf_loopback_probe #(
  parameter int PKT_W     = 49,
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 3,
  parameter int LAT_W     = 8,
  localparam int RW =
    ($clog2(MAX_RETRY + 1) < 2) ? 2 : $clog2(MAX_RETRY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PKT_W-2:0] tx_payload,
  output logic [PKT_W-1:0] dout_leaf_bft2interface,
  output logic             resend,
  input  logic [PKT_W-1:0] din_leaf_interface2bft,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [RW-1:0]    retries,
  output logic [LAT_W-1:0] latency
);

  localparam int TW =
    ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);
  localparam int LAT_MAX =
    (LAT_W >= 31) ? 2147483647 : (1 << LAT_W) - 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PKT_W-2:0] payload;
  logic [TW-1:0]    timer;
  logic [PKT_W-1:0] exp_pkt;
  logic             start_ok;
  logic             hit;
  logic             expired;
  logic             can_retry;

  logic [PKT_W-1:0] pkt_nxt;
  logic [PKT_W-1:0] dout_nxt;
  logic             resend_nxt;
  logic             done_nxt;
  logic             busy_nxt;
  logic [LAT_W-1:0] lat_sat;

  assign exp_pkt   = {1'b1, payload};
  assign start_ok  = (state == IDLE) && start;
  assign hit       = (state == WAIT) &&
                     (din_leaf_interface2bft == exp_pkt);
  assign expired   = (state == WAIT) &&
                     (timer == TW'(TIMEOUT - 1));
  assign can_retry = (retries < RW'(MAX_RETRY));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; a match in the timeout cycle beats the retry.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = SEND;
      SEND: state_nxt = WAIT;
      WAIT: begin
        if (hit) begin
          state_nxt = DONE;
        end else if (expired) begin
          state_nxt = can_retry ? SEND : DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from next state.
  always_comb begin
    pkt_nxt    = start_ok ? {1'b1, tx_payload} : exp_pkt;
    resend_nxt = (state_nxt == SEND);
    done_nxt   = (state_nxt == DONE);
    busy_nxt   = (state_nxt != IDLE);
    dout_nxt   = '0;
    if (state_nxt == SEND || state_nxt == WAIT) begin
      dout_nxt = pkt_nxt;
    end
    if (int'(timer) >= LAT_MAX) begin
      lat_sat = '1;
    end else begin
      lat_sat = LAT_W'(timer) + LAT_W'(1);
    end
  end

  // Output registers, payload latch, wait timer and result flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_leaf_bft2interface <= '0;
      resend  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      retries <= '0;
      latency <= '0;
      payload <= '0;
      timer   <= '0;
    end else begin
      dout_leaf_bft2interface <= dout_nxt;
      resend <= resend_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      if (start_ok) begin
        payload <= tx_payload;
        pass    <= 1'b0;
        fail    <= 1'b0;
        retries <= '0;
        latency <= '0;
      end
      if (state == SEND) begin
        timer <= '0;
      end
      if (hit) begin
        pass    <= 1'b1;
        latency <= lat_sat;
      end else if (expired) begin
        if (can_retry) begin
          retries <= retries + RW'(1);
        end else begin
          fail <= 1'b1;
        end
      end else if (state == WAIT) begin
        timer <= timer + TW'(1);
      end
    end
  end

endmodule
